fp16_adder: RTL and testbench

- Registered IEEE-754 binary16 (half-precision) adder/subtractor.
- Computes s = a + b, or a − b when sub=1, with round-to-nearest-even and full special-value handling.
- Used as the floating-point add primitive in the datapath: a single-cycle combinational core followed by one output register.

---
 rtl/fp16_adder.sv | 83 ++++++++
 tb/tb_fp16_adder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/fp16_adder.sv
// Registered binary16 adder/subtractor: a combinational align/add/normalize/round
// core feeding one output register, with RNE rounding and full special handling.
module fp16_adder (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        sub,
   output logic [15:0] s
);

   logic [15:0] b_eff, l_op, s_op, s_d, s_q;
   logic        a_nan, b_nan, a_inf, b_inf, swap, eff_sub, rnd_up;
   logic [4:0]  el, es, d, lzc, sh, e_fld;
   logic [13:0] ml, ms, ms_al, norm;
   logic [27:0] ext;
   logic [14:0] sum, packed_r;
   logic [5:0]  e_res;

   always_comb begin
      b_eff = {b[15] ^ sub, b[14:0]};
      a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
      b_nan = (b_eff[14:10] == 5'h1F) && (b_eff[9:0] != 10'd0);
      a_inf = (a[14:0] == 15'h7C00);
      b_inf = (b_eff[14:0] == 15'h7C00);

      swap = b_eff[14:0] > a[14:0];
      l_op = swap ? b_eff : a;
      s_op = swap ? a : b_eff;
      el   = (l_op[14:10] == 5'd0) ? 5'd1 : l_op[14:10];
      es   = (s_op[14:10] == 5'd0) ? 5'd1 : s_op[14:10];
      // significand layout: hidden bit, 10 fraction bits, guard, round, sticky
      ml   = {(l_op[14:10] != 5'd0), l_op[9:0], 3'b000};
      ms   = {(s_op[14:10] != 5'd0), s_op[9:0], 3'b000};
      d    = el - es;

      ext = {ms, 14'd0} >> d;
      if (d >= 5'd14) ms_al = {13'd0, |ms};
      else            ms_al = ext[27:14] | {13'd0, |ext[13:0]};

      eff_sub = l_op[15] ^ s_op[15];
      sum     = eff_sub ? ({1'b0, ml} - {1'b0, ms_al}) : ({1'b0, ml} + {1'b0, ms_al});

      lzc = 5'd14;
      for (int i = 0; i < 14; i++)
         if (sum[i]) lzc = 5'(13 - i);

      sh = 5'd0;
      if (sum[14]) begin
         norm  = {sum[14:2], sum[1] | sum[0]};
         e_res = {1'b0, el} + 6'd1;
         e_fld = e_res[4:0];
      end else begin
         // never shift below exponent 1; what remains unnormalized is a subnormal
         sh    = (lzc < el - 5'd1) ? lzc : el - 5'd1;
         norm  = sum[13:0] << sh;
         e_res = {1'b0, el} - {1'b0, sh};
         e_fld = norm[13] ? e_res[4:0] : 5'd0;
      end

      // adding the round bit to the packed exp/frac carries naturally into the
      // exponent, covering mantissa overflow, subnormal->normal and overflow to Inf
      rnd_up   = norm[2] & (norm[3] | norm[1] | norm[0]);
      packed_r = {e_fld, norm[12:3]} + {14'd0, rnd_up};

      s_d = {l_op[15], packed_r};
      if (e_res >= 6'd31) s_d = {l_op[15], 15'h7C00};
      if (sum == 15'd0)   s_d = eff_sub ? 16'h0000 : {l_op[15], 15'd0};

      if (a_inf && b_inf) s_d = (a[15] == b_eff[15]) ? a : 16'h7E00;
      else if (a_inf)     s_d = a;
      else if (b_inf)     s_d = b_eff;
      if (a_nan || b_nan) s_d = 16'h7E00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) s_q <= 16'h0000;
      else     s_q <= s_d;
   end

   assign s = s_q;

endmodule

// File: tb/tb_fp16_adder.sv
// Directed and randomized checks of fp16_adder against an exact-integer
// reference model (values scaled by 2^24, then rounded back to binary16).
module tb_fp16_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] a, b, s;
   logic        sub;
   int          total = 0;
   int          bad = 0;

   fp16_adder dut (.clk(clk), .rst(rst), .a(a), .b(b), .sub(sub), .s(s));

   always #5 clk = ~clk;

   function automatic longint mag(input logic [15:0] x);
      longint m, e;
      e = (x[14:10] == 5'd0) ? 1 : longint'(x[14:10]);
      m = longint'(x[9:0]) + ((x[14:10] == 5'd0) ? 0 : 1024);
      return m << (e - 1);
   endfunction

   function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y0, input logic sb);
      logic [15:0] y;
      logic        xn, yn, xi, yi, sg;
      longint      tot, n, step, q, rem;
      int          e;
      y  = {y0[15] ^ sb, y0[14:0]};
      xn = (x[14:10] == 5'h1F) && (x[9:0] != 0);
      yn = (y[14:10] == 5'h1F) && (y[9:0] != 0);
      xi = (x[14:0] == 15'h7C00);
      yi = (y[14:0] == 15'h7C00);
      if (xn || yn) return 16'h7E00;
      if (xi && yi) return (x[15] == y[15]) ? x : 16'h7E00;
      if (xi) return x;
      if (yi) return y;
      tot = (x[15] ? -mag(x) : mag(x)) + (y[15] ? -mag(y) : mag(y));
      if (tot == 0) return (x[15] && y[15]) ? 16'h8000 : 16'h0000;
      sg = tot < 0;
      n  = sg ? -tot : tot;
      e  = 1;
      while (n >= (longint'(2048) << (e - 1))) e++;
      step = longint'(1) << (e - 1);
      q    = n / step;
      rem  = n % step;
      if (2 * rem > step || (2 * rem == step && q[0])) q++;
      if (q == 2048) begin
         q = 1024;
         e++;
      end
      if (e > 30) return {sg, 15'h7C00};
      if (q < 1024) return {sg, 5'd0, q[9:0]};
      return {sg, 5'(e), q[9:0]};
   endfunction

   task automatic chk(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                      input logic [15:0] expv, input string tag);
      a   = ta;
      b   = tb_v;
      sub = ts;
      @(posedge clk);
      #1;
      total++;
      assert (s === expv) else begin
         bad++;
         $error("FAIL %s: a=%h b=%h sub=%0d got %h want %h", tag, ta, tb_v, ts, s, expv);
      end
   endtask

   initial begin
      logic [15:0] ra, rb;
      logic        rs;
      rst = 1'b1;
      a   = 16'h3C00;
      b   = 16'h3C00;
      sub = 1'b0;
      #3;
      total++;
      assert (s === 16'h0000) else begin
         bad++;
         $error("FAIL reset_state: got %h want 0000", s);
      end
      @(negedge clk);
      rst = 1'b0;

      chk(16'h43E2, 16'hC1AC, 1'b0, 16'h3C6C, "rst_release");
      chk(16'h0FCC, 16'h8ADB, 1'b0, 16'h0C5E, "mixed0");
      chk(16'hC49A, 16'h4429, 1'b0, 16'hB710, "mixed1");
      chk(16'hBA9D, 16'h4148, 1'b0, 16'h3F42, "mixed2");
      chk(16'h0A6A, 16'h92BA, 1'b0, 16'h9120, "mixed3");
      chk(16'h522C, 16'h87E6, 1'b0, 16'h522C, "gap0");
      chk(16'h6DA0, 16'hAB89, 1'b0, 16'h6DA0, "gap1");
      chk(16'hBA9D, 16'h3A9D, 1'b0, 16'h0000, "cancel");
      chk(16'h3C00, 16'h3C00, 1'b1, 16'h0000, "sub_cancel");
      chk(16'h4000, 16'h3C00, 1'b1, 16'h3C00, "sub_2m1");
      chk(16'hFE00, 16'hF5CB, 1'b0, 16'h7E00, "nan_in");
      chk(16'h7C00, 16'hFC00, 1'b0, 16'h7E00, "inf_m_inf");
      chk(16'h7C00, 16'h3C00, 1'b0, 16'h7C00, "inf_fin");
      chk(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, "overflow");
      chk(16'h0001, 16'h0001, 1'b0, 16'h0002, "subn_add");
      chk(16'h03FF, 16'h0001, 1'b0, 16'h0400, "subn_to_norm");
      // 1000 is 2^-11, exactly half an ulp of 1.0: ties go to the even neighbour
      chk(16'h3C00, 16'h1000, 1'b0, 16'h3C00, "tie_even_down");
      chk(16'h3C01, 16'h1000, 1'b0, 16'h3C02, "tie_even_up");
      chk(16'h3C00, 16'h0C00, 1'b0, 16'h3C00, "below_half");
      chk(16'h8000, 16'h8000, 1'b0, 16'h8000, "negz_negz");
      chk(16'h0000, 16'h8000, 1'b0, 16'h0000, "posz_negz");

      // asynchronous reset mid-cycle with a nonzero result held
      chk(16'h3C00, 16'h3C00, 1'b0, 16'h4000, "pre_rst");
      #3;
      rst = 1'b1;
      #1;
      total++;
      assert (s === 16'h0000) else begin
         bad++;
         $error("FAIL async_rst: got %h want 0000", s);
      end
      @(negedge clk);
      rst = 1'b0;
      chk(16'h4000, 16'h3C00, 1'b0, 16'h4200, "post_rst");

      for (int i = 0; i < 600; i++) begin
         ra = 16'($urandom);
         rs = 1'($urandom);
         case (i % 4)
            0: rb = 16'($urandom);
            1: rb = {1'($urandom), ra[14:0] ^ 15'($urandom_range(0, 255))};
            2: begin
               ra = ra & 16'h87FF;
               rb = 16'($urandom) & 16'h87FF;
            end
            default: rb = {1'($urandom), ra[14:10] ^ 5'($urandom_range(0, 3)), 10'($urandom)};
         endcase
         chk(ra, rb, rs, ref_add(ra, rb, rs), "random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
